// File: rtl/xfmat2axivideo_tx.sv
// xfMat FIFO to AXI4-Stream video transmitter with ap_ctrl frame handshake.
// Optional macro TX_BLOCK_MON_EN enables the registered stall indications on block_sigs.
module xfmat2axivideo_tx #(
    parameter int DATA_W = 24,
    parameter int ROWS_W = 10,
    parameter int COLS_W = 11
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ROWS_W-1:0] rows,
    input  logic [COLS_W-1:0] cols,
    input  logic [DATA_W-1:0] img_dout,
    input  logic              img_empty_n,
    output logic              img_read,
    output logic [DATA_W-1:0] m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    input  logic              m_axis_video_tready,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    output logic [1:0]        block_sigs,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ROWS_W-1:0] rows_r, row;
    logic [COLS_W-1:0] cols_r, col;
    logic              pix_rem;
    logic [DATA_W-1:0] tdata_r;
    logic              tvalid_r, tuser_r, tlast_r;
    logic              last_col, last_row, accept, load, run;

    // AXIS handshake: a beat transfers on an edge where tvalid & tready; tvalid
    // never drops and tdata/tuser/tlast never change while a beat waits for tready.
    assign run      = (state == ST_RUN);
    assign last_col = (col == cols_r - COLS_W'(1));
    assign last_row = (row == rows_r - ROWS_W'(1));
    assign accept   = tvalid_r & m_axis_video_tready;
    assign load     = run & img_empty_n & (~tvalid_r | m_axis_video_tready) & pix_rem;

    assign img_read            = load;
    assign ap_idle             = (state == ST_IDLE);
    assign ap_done             = (state == ST_DONE);
    assign ap_ready            = (state == ST_DONE);
    assign m_axis_video_tdata  = tdata_r;
    assign m_axis_video_tvalid = tvalid_r;
    assign m_axis_video_tuser  = tuser_r;
    assign m_axis_video_tlast  = tlast_r;
    assign state_dbg           = state;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ap_start)
                         state_next = (rows == '0 || cols == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (!pix_rem && accept) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rows_r   <= '0;
            cols_r   <= '0;
            row      <= '0;
            col      <= '0;
            pix_rem  <= 1'b0;
            tdata_r  <= '0;
            tvalid_r <= 1'b0;
            tuser_r  <= 1'b0;
            tlast_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        rows_r  <= rows;
                        cols_r  <= cols;
                        row     <= '0;
                        col     <= '0;
                        pix_rem <= (rows != '0) && (cols != '0);
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        // A simultaneous accept simply gets overwritten by the new beat.
                        tdata_r  <= img_dout;
                        tvalid_r <= 1'b1;
                        tuser_r  <= (row == '0) && (col == '0);
                        tlast_r  <= last_col;
                        if (last_col) begin
                            col <= '0;
                            row <= row + ROWS_W'(1);
                            if (last_row) pix_rem <= 1'b0;
                        end else begin
                            col <= col + COLS_W'(1);
                        end
                    end else if (accept) begin
                        tvalid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TX_BLOCK_MON_EN
    logic [1:0] block_r;

    // bit0: beat waiting on the sink; bit1: room to load but the FIFO is empty.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            block_r <= 2'b00;
        end else begin
            block_r[0] <= run & tvalid_r & ~m_axis_video_tready;
            block_r[1] <= run & pix_rem & ~img_empty_n & (~tvalid_r | m_axis_video_tready);
        end
    end

    assign block_sigs = block_r;
`else
    assign block_sigs = 2'b00;
`endif

endmodule
